// File: rtl/weight_seq_ctrl.sv
// Walks the shared weight-ROM address 0..len-1 in step with the activation stream and emits MAC strobes aligned to the 1-cycle ROM read.
// Latency: beat at t -> mac_en/mac_x at t+1, done at t+2 after the final beat. x_ready is high only in RUN. Optional macro PERF_CNT_EN enables stall_cnt.
module weight_seq_ctrl #(
    parameter int INT_BITS = 6,
    parameter int FRC_BITS = 7,
    parameter int ADDR_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_W:0]              len,
    input  logic                         abort,
    input  logic [INT_BITS+FRC_BITS-1:0] x_data,
    input  logic                         x_valid,
    output logic                         x_ready,
    output logic [ADDR_W-1:0]            rom_addr,
    output logic [INT_BITS+FRC_BITS-1:0] mac_x,
    output logic                         mac_en,
    output logic                         mac_clr,
    output logic                         mac_last,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [15:0]                  stall_cnt
);
    localparam int DATA_W = INT_BITS + FRC_BITS;
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]   mac_x_q, mac_x_d;
    logic                mac_en_q, mac_en_d;
    logic                mac_clr_q, mac_clr_d;
    logic                mac_last_q, mac_last_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                len_ok;

    assign len_ok = (len != '0) && (len <= DEPTH_V);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        mac_x_d    = mac_x_q;
        mac_en_d   = 1'b0;
        mac_clr_d  = 1'b0;
        mac_last_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state_d = RUN;
                            cnt_d   = '0;
                            // Keep the final index rather than len so the compare stays ADDR_W wide.
                            last_d  = len[ADDR_W-1:0] - ADDR_W'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (x_valid) begin
                        mac_x_d    = x_data;
                        mac_en_d   = 1'b1;
                        mac_clr_d  = (cnt_q == '0);
                        mac_last_d = (cnt_q == last_q);
                        if (cnt_q == last_q) begin
                            cnt_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            mac_x_q    <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            mac_x_q    <= mac_x_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
            mac_last_q <= mac_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign x_ready  = (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign rom_addr = cnt_q;
    assign mac_x    = mac_x_q;
    assign mac_en   = mac_en_q;
    assign mac_clr  = mac_clr_q;
    assign mac_last = mac_last_q;
    assign done     = done_q;
    assign err      = err_q;

`ifdef PERF_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start && !abort && len_ok)
            stall_d = '0;
        else if (state_q == RUN && !x_valid && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Randomised bench for weight_seq_ctrl: transaction-level expectations (beat index, data, strobes, done timing).
module tb_weight_seq_ctrl;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 13;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n, start, abort, x_valid;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] x_data;
    logic              x_ready, mac_en, mac_clr, mac_last, busy, done, err;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] mac_x;
    logic [15:0]       stall_cnt;

    int errors = 0;
    int checks = 0;
    int pat[$];

    weight_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready), .rom_addr(rom_addr),
        .mac_x(mac_x), .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last),
        .busy(busy), .done(done), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // mode 0: x_valid always high, x_data = addr+1; mode 1: x_valid from pat; mode 2: random valid and stray starts
    task automatic drive_pass(input int plen, input int mode, input string tag);
        int k = 0, pi = 0, stalls = 0, done_in = -1, prev_k = 0;
        bit prev_beat = 0, got_done = 0, v;
        logic [DATA_W-1:0] prev_dat = '0;
        @(negedge clk);
        start = 1'b1; len = (ADDR_W+1)'(plen); x_valid = 1'b0; abort = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (prev_beat) begin
                checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL %s mac_en beat %0d: got %b want 1", tag, prev_k, mac_en); end
                checks++; if (mac_x !== prev_dat) begin errors++; $display("FAIL %s mac_x beat %0d: got %h want %h", tag, prev_k, mac_x, prev_dat); end
                checks++; if (mac_clr !== (prev_k == 0)) begin errors++; $display("FAIL %s mac_clr beat %0d: got %b want %b", tag, prev_k, mac_clr, prev_k == 0); end
                checks++; if (mac_last !== (prev_k == plen-1)) begin errors++; $display("FAIL %s mac_last beat %0d: got %b want %b", tag, prev_k, mac_last, prev_k == plen-1); end
            end else begin
                checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL %s mac_en idle: got %b want 0", tag, mac_en); end
            end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err: got %b want 0", tag, err); end
            if (done_in == 0) begin
                checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s done/busy at t+2: got %b/%b want 1/0", tag, done, busy); end
                got_done = 1;
                break;
            end
            checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s done/busy mid-pass: got %b/%b want 0/1", tag, done, busy); end
            if (done_in > 0) done_in--;
            start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            len = '0;
            x_data = DATA_W'($urandom);
            prev_beat = 0;
            if (k < plen) begin
                if (mode == 0) v = 1;
                else if (mode == 1) v = (pi < pat.size()) ? (pat[pi] != 0) : 1;
                else v = ($urandom_range(0, 3) != 0);
                pi++;
                if (mode == 0) x_data = DATA_W'(k + 1);
                x_valid = v;
                checks++; if (x_ready !== 1'b1) begin errors++; $display("FAIL %s x_ready run: got %b want 1", tag, x_ready); end
                checks++; if (rom_addr !== ADDR_W'(k)) begin errors++; $display("FAIL %s rom_addr: got %0d want %0d", tag, rom_addr, k); end
                if (v) begin
                    prev_beat = 1; prev_dat = x_data; prev_k = k; k++;
                    if (k == plen) done_in = 1;
                end else begin
                    stalls++;
                end
            end else begin
                x_valid = 1'($urandom_range(0, 1));
                checks++; if (x_ready !== 1'b0) begin errors++; $display("FAIL %s x_ready drain: got %b want 0", tag, x_ready); end
            end
        end
        start = 1'b0; x_valid = 1'b0;
        checks++; if (!got_done) begin errors++; $display("FAIL %s timeout: done got 0 want 1", tag); end
`ifdef PERF_CNT_EN
        checks++; if (stall_cnt !== 16'(stalls)) begin errors++; $display("FAIL %s stall_cnt: got %0d want %0d", tag, stall_cnt, stalls); end
`else
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL %s stall_cnt: got %0d want 0", tag, stall_cnt); end
`endif
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        rst_n = 1'b0; start = 1'b1; len = 7'd4; abort = 1'b0; x_valid = 1'b1; x_data = 13'h5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {rom_addr, mac_x, mac_en, mac_clr, mac_last, busy, done, err, x_ready, stall_cnt[3:0]};
            checks++; if (obs !== '0) begin errors++; $display("FAIL reset outputs cycle %0d: got %h want 0", i, obs); end
        end
        rst_n = 1'b1; start = 1'b0; x_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({err, busy, x_ready, mac_en} !== 4'b0) begin errors++; $display("FAIL post-reset idle: got %b want 0000", {err, busy, x_ready, mac_en}); end
        end
    endtask

    task automatic test_full_pass();
        drive_pass(DEPTH, 0, "full32");
    endtask

    task automatic test_stalls();
        pat = '{1, 0, 0, 1, 1, 0, 1};
        drive_pass(4, 1, "stall4");
    endtask

    task automatic test_len1();
        drive_pass(1, 0, "len1");
        pat = '{0, 0, 1};
        drive_pass(1, 1, "len1stall");
    endtask

    task automatic test_illegal();
        int lens[4];
        lens = '{0, 33, 63, 0};
        lens[3] = $urandom_range(34, 62);
        foreach (lens[i]) begin
            @(negedge clk);
            start = 1'b1; len = (ADDR_W+1)'(lens[i]);
            @(negedge clk);
            start = 1'b0;
            checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL illegal len %0d err/busy: got %b want 10", lens[i], {err, busy}); end
            @(negedge clk);
            checks++; if ({err, busy, mac_en} !== 3'b0) begin errors++; $display("FAIL illegal len %0d after: got %b want 000", lens[i], {err, busy, mac_en}); end
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; len = 7'd4;
        @(negedge clk);
        len = 7'd0;
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL start+abort legal: got busy/err %b want 00", {busy, err}); end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL start+abort illegal: got busy/err %b want 00", {busy, err}); end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1; len = 7'd16; x_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            x_valid = 1'b1; x_data = DATA_W'($urandom);
            if (b == 4) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0; x_valid = 1'b0;
        checks++; if ({mac_en, mac_clr, mac_last, busy, x_ready} !== 5'b0) begin errors++; $display("FAIL abort next cycle: got %b want 00000", {mac_en, mac_clr, mac_last, busy, x_ready}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({done, mac_en, busy} !== 3'b0) begin errors++; $display("FAIL abort quiet %0d: got %b want 000", i, {done, mac_en, busy}); end
        end
        drive_pass(2, 0, "afterabort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            drive_pass($urandom_range(1, DEPTH), 2, "random");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; x_valid = 1'b0; len = '0; x_data = '0;
        test_reset();
        test_full_pass();
        test_stalls();
        test_len1();
        test_illegal();
        test_start_abort();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
